// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin stream multiplexer:
// arbitration mode encodings and the channel-select width helper.
package stream_mux_rr_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Width of a channel index. It is at least one bit, so a select
    // port always exists even for the smallest channel counts.
    function automatic int sel_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant generator. In round-robin mode the search starts at the
// pointer and wraps from N-1 to 0. In fixed mode the search starts at 0,
// so the lowest-index request wins. No grant is issued while i_en is low.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        i_req,
    input  logic [sel_w(N)-1:0] i_ptr,
    input  logic                i_mode,
    input  logic                i_en,
    output logic [N-1:0]        o_grant
);

    localparam int SW = sel_w(N);

    logic [SW-1:0] w_start;
    logic [SW-1:0] w_idx;
    logic          w_found;

    // Rotating priority search: grant the first requester found at or after the start index
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (i_mode == 1'b1) begin
            w_start = i_ptr;
        end else begin
            w_start = '0;
        end
        for (int k = 0; k < N; k++) begin
            w_idx = SW'((int'(w_start) + k) % N);
            if (i_en && !w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a one-word registered output
// stage. Channel selection is either fixed priority or round robin. A new
// word may be loaded whenever the output register is empty or is being
// drained in the same cycle, which gives one word per cycle with no bubbles.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 4,
    parameter int MODE   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    output logic [N_CH-1:0]          in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [sel_w(N_CH)-1:0]   out_sel
);

    localparam int SW = sel_w(N_CH);

    logic              w_load;
    logic              w_en;
    logic              w_mode;
    logic              w_xfer_in;
    logic [N_CH-1:0]   w_grant;
    logic [SW-1:0]     w_sel;
    logic [SW-1:0]     w_ptr_next;
    logic [DATA_W-1:0] w_data;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [SW-1:0]     r_out_sel;
    logic [SW-1:0]     r_ptr;

    // The register can take a word when empty or when its word leaves this
    // cycle. Reset also gates the grant, so in_ready stays low while rst_n is low.
    assign w_load = !r_out_valid || out_ready;
    assign w_en   = w_load && rst_n;
    assign w_mode = (MODE == MODE_RR) ? 1'b1 : 1'b0;

    rr_arbiter #(
        .N (N_CH)
    ) u_arb (
        .i_req   (in_valid),
        .i_ptr   (r_ptr),
        .i_mode  (w_mode),
        .i_en    (w_en),
        .o_grant (w_grant)
    );

    // The grant is only asserted on a valid request, so any grant bit
    // means an input transfer takes place this cycle.
    assign in_ready  = w_grant;
    assign w_xfer_in = |w_grant;

    // Encode the one-hot grant, select the payload, and compute the next pointer
    always_comb begin
        w_sel  = '0;
        w_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant[i]) begin
                w_sel  = SW'(i);
                w_data = in_data[i*DATA_W +: DATA_W];
            end else begin
                w_sel  = w_sel;
            end
        end
        if (w_sel == SW'(N_CH - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = w_sel + SW'(1'b1);
        end
    end

    // Output word register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_xfer_in) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_sel   <= w_sel;
            r_ptr       <= w_ptr_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: three instances (4-ch round robin, 4-ch fixed
// priority, 3-ch 8-bit round robin) driven by directed and random stimulus.
module tb_stream_mux_rr;

    logic clk;
    logic rst_n;

    // 4-channel round robin instance
    logic [15:0] a_data;
    logic [3:0]  a_valid, a_in_ready;
    logic [3:0]  a_out_data;
    logic        a_out_valid, a_ready;
    logic [1:0]  a_out_sel;

    // 4-channel fixed priority instance
    logic [15:0] f_data;
    logic [3:0]  f_valid, f_in_ready;
    logic [3:0]  f_out_data;
    logic        f_out_valid, f_ready;
    logic [1:0]  f_out_sel;

    // 3-channel, 8-bit round robin instance
    logic [23:0] p_data;
    logic [2:0]  p_valid, p_in_ready;
    logic [7:0]  p_out_data;
    logic        p_out_valid, p_ready;
    logic [1:0]  p_out_sel;

    int checks;
    int errors;

    stream_mux_rr #(.N_CH(4), .DATA_W(4), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_ready), .out_sel(a_out_sel));

    stream_mux_rr #(.N_CH(4), .DATA_W(4), .MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_data(f_data), .in_valid(f_valid),
        .in_ready(f_in_ready), .out_data(f_out_data), .out_valid(f_out_valid),
        .out_ready(f_ready), .out_sel(f_out_sel));

    stream_mux_rr #(.N_CH(3), .DATA_W(8), .MODE(1)) u_p3 (
        .clk(clk), .rst_n(rst_n), .in_data(p_data), .in_valid(p_valid),
        .in_ready(p_in_ready), .out_data(p_out_data), .out_valid(p_out_valid),
        .out_ready(p_ready), .out_sel(p_out_sel));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference grant: the requesting channel closest to ptr going upward with wrap
    function automatic int pick(input logic [15:0] v, input int n, input int p);
        int best;
        int bd;
        int d;
        best = -1;
        bd   = n;
        for (int i = 0; i < n; i++) begin
            if (v[i]) begin
                d = (i - p + n) % n;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        a_valid = 4'hF; a_ready = 1'b0; a_data = 16'h4321;
        f_valid = 4'h0; f_ready = 1'b0; f_data = 16'h0000;
        p_valid = 3'b000; p_ready = 1'b0; p_data = 24'h000000;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 4'b0000 || a_out_valid !== 1'b0 || a_out_data !== 4'h0 || a_out_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_data=%h out_sel=%0d, want 0000/0/0/0",
                     a_in_ready, a_out_valid, a_out_data, a_out_sel);
        end
        rst_n   = 1'b1;
        a_valid = 4'b0001; a_data = 16'h0007;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 4'h7) begin
            errors++;
            $display("FAIL reset_preload: out_valid=%b out_data=%h, want 1/7", a_out_valid, a_out_data);
        end
        #2;
        a_valid = 4'hF;
        rst_n   = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 4'h0 || a_in_ready !== 4'b0000 || a_out_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_async: out_valid=%b out_data=%h in_ready=%b out_sel=%0d, want 0/0/0000/0",
                     a_out_valid, a_out_data, a_in_ready, a_out_sel);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        a_valid = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_empty: out_valid=%b, want 0", a_out_valid);
        end
    endtask

    task automatic test_rr_fairness();
        logic [3:0] exp_rdy;
        int ch;
        @(negedge clk);
        a_valid = 4'hF; a_ready = 1'b1; a_data = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int k = 0; k < 5; k++) begin
            ch      = k % 4;
            exp_rdy = 4'b0001 << ch;
            #1;
            checks++;
            if (a_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_ready[%0d]: in_ready=%b, want %b", k, a_in_ready, exp_rdy);
            end
            @(posedge clk); #1;
            checks++;
            if (a_out_sel !== 2'(ch) || a_out_data !== 4'(ch + 1) || a_out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_order[%0d]: out_sel=%0d out_data=%0d, want %0d/%0d",
                         k, a_out_sel, a_out_data, ch, ch + 1);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        f_valid = 4'b1010; f_ready = 1'b1; f_data = 16'hDCBA;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (f_in_ready !== 4'b0010) begin
                errors++;
                $display("FAIL fp_ready[%0d]: in_ready=%b, want 0010", k, f_in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (f_out_sel !== 2'd1 || f_out_data !== 4'hB) begin
                errors++;
                $display("FAIL fp_grant[%0d]: out_sel=%0d out_data=%h, want 1/b", k, f_out_sel, f_out_data);
            end
            @(negedge clk);
        end
        f_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy;
        a_valid = 4'b0000; a_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b, want 0", a_out_valid);
        end
        @(negedge clk);
        a_valid = 4'b0001; a_ready = 1'b0; a_data = 16'h0009;
        for (int c = 0; c < 5; c++) begin
            exp_rdy = (c == 0) ? 4'b0001 : 4'b0000;
            #1;
            checks++;
            if (a_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL bp_ready[%0d]: in_ready=%b, want %b", c, a_in_ready, exp_rdy);
            end
            @(posedge clk); #1;
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== 4'h9 || a_out_sel !== 2'd0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out_data=%h out_sel=%0d, want 1/9/0",
                         c, a_out_valid, a_out_data, a_out_sel);
            end
            @(negedge clk);
            a_data = 16'h0005;
        end
        a_ready = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_release_ready: in_ready=%b, want 0001", a_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 4'h5) begin
            errors++;
            $display("FAIL bp_release_data: out_valid=%b out_data=%h, want 1/5", a_out_valid, a_out_data);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        a_valid = 4'b0000; a_ready = 1'b1;
        @(negedge clk);
        a_valid = 4'b0100; a_data = 16'h0300;
        @(posedge clk); #1;
        checks++;
        if (a_out_sel !== 2'd2 || a_out_data !== 4'h3) begin
            errors++;
            $display("FAIL wrap_setup: out_sel=%0d out_data=%h, want 2/3", a_out_sel, a_out_data);
        end
        @(negedge clk);
        a_valid = 4'b0011; a_data = 16'h00BA;
        #1;
        checks++;
        if (a_in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant: in_ready=%b, want 0001", a_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_sel !== 2'd0 || a_out_data !== 4'hA) begin
            errors++;
            $display("FAIL wrap_out: out_sel=%0d out_data=%h, want 0/a", a_out_sel, a_out_data);
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ptr: in_ready=%b, want 0010", a_in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_sel !== 2'd1 || a_out_data !== 4'hB) begin
            errors++;
            $display("FAIL wrap_next: out_sel=%0d out_data=%h, want 1/b", a_out_sel, a_out_data);
        end
        @(negedge clk);
        a_valid = 4'b0000;
    endtask

    task automatic test_param3_random();
        logic       m_valid;
        logic [7:0] m_data;
        int         m_sel;
        int         m_ptr;
        int         seq[3];
        int         rx[3];
        int         n_in;
        int         n_out;
        int         g;
        logic       load;
        logic [2:0] exp_rdy;
        logic [7:0] word;
        m_valid = 1'b0; m_data = 8'h00; m_sel = 0; m_ptr = 0;
        n_in = 0; n_out = 0;
        for (int c = 0; c < 3; c++) begin
            seq[c] = 0;
            rx[c]  = 0;
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (t < 290) begin
                p_valid = 3'($urandom_range(0, 7));
                p_ready = ($urandom_range(0, 3) != 0);
            end else begin
                p_valid = 3'b000;
                p_ready = 1'b1;
            end
            for (int c = 0; c < 3; c++) begin
                p_data[c*8 +: 8] = {2'(c), 6'(seq[c])};
            end
            #1;
            load    = !m_valid || p_ready;
            g       = load ? pick({13'b0, p_valid}, 3, m_ptr) : -1;
            exp_rdy = (g >= 0) ? (3'b001 << g) : 3'b000;
            checks++;
            if (p_in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL p3_ready[%0d]: in_ready=%b, want %b", t, p_in_ready, exp_rdy);
            end
            if (m_valid && p_ready) begin
                checks++;
                if (p_out_sel > 2'd2 || p_out_data[7:6] !== p_out_sel ||
                    p_out_data[5:0] !== 6'(rx[p_out_sel])) begin
                    errors++;
                    $display("FAIL p3_scoreboard[%0d]: out_sel=%0d out_data=%h, want sel<3 with seq %0d",
                             t, p_out_sel, p_out_data, rx[p_out_sel % 3]);
                end
                if (p_out_sel <= 2'd2) begin
                    rx[p_out_sel] = rx[p_out_sel] + 1;
                end
                n_out++;
            end
            if (g >= 0) begin
                word    = {2'(g), 6'(seq[g])};
                m_valid = 1'b1;
                m_data  = word;
                m_sel   = g;
                m_ptr   = (g + 1) % 3;
                seq[g]  = seq[g] + 1;
                n_in++;
            end else if (p_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk); #1;
            checks++;
            if (p_out_valid !== m_valid || (m_valid && (p_out_data !== m_data || p_out_sel !== 2'(m_sel)))) begin
                errors++;
                $display("FAIL p3_out[%0d]: valid=%b data=%h sel=%0d, want %b/%h/%0d",
                         t, p_out_valid, p_out_data, p_out_sel, m_valid, m_data, m_sel);
            end
        end
        checks++;
        if (n_out != n_in) begin
            errors++;
            $display("FAIL p3_count: words out=%0d, want %0d", n_out, n_in);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_wrap();
        test_param3_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N_CH, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter DATA_W, default 4: payload width per channel, legal range 1..64.
REQ-003 Parameter MODE, default 1: arbitration mode; 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_data, input, N_CH*DATA_W: channel i payload in bits [i*DATA_W +: DATA_W].
REQ-007 Port in_valid, input, N_CH: channel i offers a word.
REQ-008 Port in_ready, output, N_CH: channel i word accepted this cycle.
REQ-009 Port out_data, output, DATA_W: registered selected payload.
REQ-010 Port out_valid, output, 1: out_data holds a word.
REQ-011 Port out_ready, input, 1: downstream accepts the word.
REQ-012 Port out_sel, output, max(1,clog2(N_CH)): source channel index of out_data.

Function
REQ-013 Input transfer on channel i occurs when in_valid[i] and in_ready[i] are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-014 Load enable = !out_valid || out_ready; in_ready SHALL be all-zero when load enable is 0.
REQ-015 When load enable is 1 and at least one in_valid bit is set, exactly one in_ready bit SHALL be 1, namely the granted channel; otherwise in_ready is all-zero.
REQ-016 in_ready SHALL depend only on in_valid, out_valid, out_ready, and state, never on in_data.
REQ-017 MODE 0: grant = lowest-index set in_valid bit.
REQ-018 MODE 1: grant = first set in_valid bit at or after the pointer, searching upward with wrap from N_CH-1 to 0.
REQ-019 MODE 1: on each input transfer the pointer SHALL become (grant+1) mod N_CH; the pointer is unchanged otherwise.
REQ-020 On an input transfer, out_data, out_sel, and out_valid=1 SHALL be registered at the next edge; the input-to-output latency is 1 cycle.
REQ-021 An output transfer without a simultaneous input transfer SHALL clear out_valid at the next edge; out_data and out_sel hold their values.
REQ-022 A simultaneous output and input transfer SHALL replace the word with no bubble, sustaining 1 word/cycle.
REQ-023 While out_valid=1 and out_ready=0, out_data, out_sel, and out_valid SHALL remain stable.
REQ-024 No word SHALL be dropped or duplicated; per-channel order is preserved.
REQ-025 MODE 1 with all channels continuously valid SHALL grant the channels in the cyclic order 0,1,…,N_CH-1,0.

Reset
REQ-026 Asserting rst_n low SHALL immediately force out_valid=0, out_data=0, out_sel=0, and pointer=0, independent of clk.
REQ-027 During reset in_ready SHALL be all-zero.
REQ-028 Reset deassertion mid-stream SHALL leave the block empty; a word held before reset is discarded.

Structure
REQ-029 A shared package SHALL hold the MODE constants (MODE_FIXED=0, MODE_RR=1) and a clog2-based select-width function.
REQ-030 Grant logic SHALL be a single sub-module rr_arbiter (inputs: request vector, pointer, mode, enable; output: one-hot grant); the datapath mux and output register reside in stream_mux_rr.

Verification
REQ-031 Reset check: rst_n=0 asserted mid-cycle with out_valid=1 -> out_valid=0, out_data=0, and in_ready=0 immediately, without waiting for a clock edge.
REQ-032 Round-robin fairness: N_CH=4, MODE=1, all in_valid=1, out_ready=1, in_data[i]=i+1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles and out_data sequence 1,2,3,4,1.
REQ-033 Fixed priority: MODE=0, in_valid=4'b1010, out_ready=1 -> channel 1 granted on every cycle and channel 3 starved.
REQ-034 Backpressure: out_ready=0 for 5 cycles with in_valid=4'b0001 -> one word accepted, in_ready=0 for the remaining cycles, and out_data stable; when out_ready returns to 1, the next word is accepted in the same cycle.
REQ-035 Wrap-around: MODE=1, pointer=3, in_valid=4'b0011 -> grant channel 0 and pointer becomes 1.
REQ-036 Parametric: N_CH=3, DATA_W=8, random valid/ready patterns -> scoreboard sees no loss, duplication, or per-channel reordering, and out_sel < 3 on every transfer.
